dense_activate_pipe: RTL

Elastic, parametrised pipeline stage between the dense stage and the activate stage. It carries the full dense→activate bundle (types, weight/output/input vectors, weight indices, update flag, predict value, backprop flag) through a `depth`-entry FIFO with a valid/ready handshake. Either side can stall without losing data. It also adds a synchronous flush and an occupancy count, which a fixed one-cycle delay cannot provide.

---
 rtl/dense_activate_pipe.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dense_activate_pipe.sv
// dense_activate_pipe
// Elastic FIFO stage carrying the dense -> activate bundle. in_ready and
// out_valid decode only from the registered occupancy, so neither side's
// handshake inputs reach the other side combinationally. Flush discards
// every held bundle in one edge; reset also clears entry contents so the
// *_out fields read zero straight away.
module dense_activate_pipe #(
    parameter int size            = 3,
    parameter int data_size       = 16,
    parameter int cost_type_size  = 8,
    parameter int dense_type_size = 4,
    parameter int act_type_size   = 4,
    parameter int depth           = 2,
    parameter int cnt_w           = $clog2(depth) + 1
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          flush,
    output logic [cnt_w-1:0]              count,

    input  logic [act_type_size-1:0]      act_type,
    input  logic [dense_type_size-1:0]    dense_type,
    input  logic [cost_type_size-1:0]     cost_type,
    input  logic [data_size*size-1:0]     w,
    input  logic [data_size*size-1:0]     y,
    input  logic [data_size*size-1:0]     x,
    input  logic [31:0]                   w_layer_index,
    input  logic [31:0]                   w_row_index,
    input  logic                          is_update,
    input  logic [data_size*size-1:0]     predict_value,
    input  logic                          backprop_cost,

    output logic [act_type_size-1:0]      act_type_out,
    output logic [dense_type_size-1:0]    dense_type_out,
    output logic [cost_type_size-1:0]     cost_type_out,
    output logic [data_size*size-1:0]     w_out,
    output logic [data_size*size-1:0]     y_out,
    output logic [data_size*size-1:0]     x_out,
    output logic [31:0]                   w_layer_index_out,
    output logic [31:0]                   w_row_index_out,
    output logic                          is_update_out,
    output logic [data_size*size-1:0]     predict_value_out,
    output logic                          backprop_cost_out
);

    localparam int vec_w   = data_size * size;
    localparam int entry_w = act_type_size + dense_type_size + cost_type_size
                           + 4 * vec_w + 64 + 2;
    localparam int ptr_w   = $clog2(depth);

    logic [entry_w-1:0] mem [depth];
    logic [entry_w-1:0] in_entry;
    logic [entry_w-1:0] head_entry;
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [cnt_w-1:0]   count_q;
    logic               push;
    logic               pop;

    // Field order is shared by pack and unpack; keep the two lists identical.
    assign in_entry = {act_type, dense_type, cost_type, w, y, x,
                       w_layer_index, w_row_index, is_update,
                       predict_value, backprop_cost};

    assign head_entry = mem[rd_ptr];

    assign {act_type_out, dense_type_out, cost_type_out, w_out, y_out, x_out,
            w_layer_index_out, w_row_index_out, is_update_out,
            predict_value_out, backprop_cost_out} = head_entry;

    assign in_ready  = (count_q < cnt_w'(depth));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // Flush wins over both transfers, so it gates them here.
    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + cnt_w'(1);
                2'b01:   count_q <= count_q - cnt_w'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; flush leaves contents alone, reset zeroes them so *_out reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

endmodule
